// File: rtl/comp_pkg.sv
// Shared types and result encodings for the bit-serial magnitude comparator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package comp_pkg;

   // Controller sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

   // One-hot result encodings, bit order {aeb, agb, alb}
   localparam logic [2:0] CMP_EQ = 3'b100;
   localparam logic [2:0] CMP_GT = 3'b010;
   localparam logic [2:0] CMP_LT = 3'b001;

   // Pack a differing-bit sense into the one-hot result layout.
   // For a bit that differs, exactly one of gt/lt is set.
   function automatic logic [2:0] cmp_sense(input logic gt, input logic lt);
      return {1'b0, gt, lt};
   endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Combinational single-bit magnitude compare cell, time-shared by the controller.
// Latency: zero (pure combinational).
// Backpressure: none; the controller decides when its outputs are used.
module cmp_bit_cell (
   input  logic a_bit,
   input  logic b_bit,
   output logic eq,
   output logic gt,
   output logic lt
);

   assign eq = ~(a_bit ^ b_bit);
   assign gt = a_bit & ~b_bit;
   assign lt = ~a_bit & b_bit;

endmodule

// File: rtl/comp_serial_ctrl.sv
// Bit-serial unsigned magnitude comparator: one bit per clock, MSB first, one shared compare cell.
// Latency: accept edge to out_valid is k+1 edges (early exit, k = matching MSBs) or WIDTH edges (full scan).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; new accept no earlier than the cycle after drain.
module comp_serial_ctrl
   import comp_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             aeb,
   output logic             agb,
   output logic             alb,
   output logic             busy
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

   cmp_state_t       r_state;
   cmp_state_t       w_state_nxt;
   logic             r_in_rdy;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IW-1:0]    r_idx;
   logic [2:0]       r_res;
   logic             r_mis;
   logic [2:0]       r_mis_res;

   logic             w_a_bit;
   logic             w_b_bit;
   logic             w_eq;
   logic             w_gt;
   logic             w_lt;
   logic             w_acc;
   logic             w_drain;
   logic             w_last;
   logic             w_stop_early;

   // The single compare cell always looks at the currently indexed bit pair
   assign w_a_bit = r_a[r_idx];
   assign w_b_bit = r_b[r_idx];

   cmp_bit_cell u_cell (
      .a_bit (w_a_bit),
      .b_bit (w_b_bit),
      .eq    (w_eq),
      .gt    (w_gt),
      .lt    (w_lt)
   );

   // in_ready is a register, so it is only ever high while the FSM sits in IDLE
   assign w_acc        = in_valid & r_in_rdy & (r_state == IDLE);
   assign w_drain      = out_ready & (r_state == DONE);
   assign w_last       = (r_idx == '0);
   assign w_stop_early = EARLY_EXIT & ~w_eq;

   // Next-state selection for the IDLE -> RUN -> DONE sequence
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_acc) w_state_nxt = RUN;
         RUN:  if (w_stop_early || w_last) w_state_nxt = DONE;
         DONE: if (w_drain) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register; in_ready held low through reset and raised on the first edge back in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_in_rdy <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_in_rdy <= (w_state_nxt == IDLE);
      end
   end

   // Operand capture, bit scan, sticky first-mismatch tracking and result registration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_idx     <= IDX_MSB;
         r_res     <= '0;
         r_mis     <= 1'b0;
         r_mis_res <= '0;
      end else if (w_acc) begin
         r_a       <= a;
         r_b       <= b;
         r_idx     <= IDX_MSB;
         r_res     <= '0;
         r_mis     <= 1'b0;
         r_mis_res <= '0;
      end else if (r_state == RUN) begin
         if (w_stop_early) begin
            // First differing bit decides the relation outright
            r_res <= cmp_sense(w_gt, w_lt);
         end else if (w_last) begin
            // Full scan finished: the earliest (most significant) mismatch wins,
            // including one found on this very last bit
            if (r_mis)
               r_res <= r_mis_res;
            else if (!w_eq)
               r_res <= cmp_sense(w_gt, w_lt);
            else
               r_res <= CMP_EQ;
         end else begin
            // Less significant mismatches never overwrite the recorded one
            if (!w_eq && !r_mis) begin
               r_mis     <= 1'b1;
               r_mis_res <= cmp_sense(w_gt, w_lt);
            end
            r_idx <= r_idx - IW'(1);
         end
      end
   end

   assign in_ready  = r_in_rdy;
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == RUN);
   assign aeb       = r_res[2];
   assign agb       = r_res[1];
   assign alb       = r_res[0];

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Self-checking bench: two WIDTH=4 instances (early exit / full scan) driven through a scoreboard.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_comp_serial_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic [1:0] in_valid = '0;
   logic [1:0] out_ready = '0;
   wire  [1:0] in_ready;
   wire  [1:0] out_valid;
   wire  [1:0] busy;
   wire  [2:0] res0;
   wire  [2:0] res1;

   typedef struct {
      int         sel;
      logic [2:0] res;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   comp_serial_ctrl #(.WIDTH(4), .EARLY_EXIT(1'b1)) u_ee1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .a         (a),
      .b         (b),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .aeb       (res0[2]),
      .agb       (res0[1]),
      .alb       (res0[0]),
      .busy      (busy[0])
   );

   comp_serial_ctrl #(.WIDTH(4), .EARLY_EXIT(1'b0)) u_ee0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .a         (a),
      .b         (b),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .aeb       (res1[2]),
      .agb       (res1[1]),
      .alb       (res1[0]),
      .busy      (busy[1])
   );

   // Reference model: one-hot {aeb, agb, alb} for an unsigned compare
   function automatic logic [2:0] exp_res(input logic [3:0] av, input logic [3:0] bv);
      if (av == bv) return 3'b100;
      if (av > bv)  return 3'b010;
      return 3'b001;
   endfunction

   // Reference model: edges from accept to out_valid (sel 0 = early exit, sel 1 = full scan)
   function automatic int exp_lat(input int sel, input logic [3:0] av, input logic [3:0] bv);
      if (sel == 1) return 4;
      for (int i = 3; i >= 0; i--)
         if (av[i] != bv[i]) return 4 - i;
      return 4;
   endfunction

   function automatic logic [2:0] get_res(input int sel);
      return (sel == 0) ? res0 : res1;
   endfunction

   // Offer operands and push the model's prediction; entered and left #1 after a rising edge
   task automatic start_cmp(input int sel, input logic [3:0] av, input logic [3:0] bv);
      int n;
      n = 0;
      while (!in_ready[sel] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (in_ready[sel] !== 1'b1) begin
         errors++;
         $display("FAIL start_ready sel=%0d in_ready=%b expected 1", sel, in_ready[sel]);
      end
      a = av;
      b = bv;
      in_valid[sel] = 1'b1;
      @(posedge clk); #1;
      in_valid[sel] = 1'b0;
      sb.push_back('{sel, exp_res(av, bv), exp_lat(sel, av, bv)});
   endtask

   // Count edges until out_valid, optionally scrambling the operand inputs every cycle
   task automatic wait_result(input int sel, input bit scramble, output int lat);
      lat = 0;
      while (!out_valid[sel] && lat < 40) begin
         if (scramble) begin
            a = 4'($urandom);
            b = 4'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain(input int sel);
      out_ready[sel] = 1'b1;
      @(posedge clk); #1;
      out_ready[sel] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (in_ready !== 2'b00 || out_valid !== 2'b00 || busy !== 2'b00) begin
         errors++;
         $display("FAIL reset_ctrl in_ready=%b out_valid=%b busy=%b expected 00/00/00", in_ready, out_valid, busy);
      end
      checks++;
      if (res0 !== 3'b000 || res1 !== 3'b000) begin
         errors++;
         $display("FAIL reset_res res0=%b res1=%b expected 000/000", res0, res1);
      end
      #10 rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 2'b00) begin
         errors++;
         $display("FAIL release_ready_early in_ready=%b expected 00", in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 2'b11) begin
         errors++;
         $display("FAIL release_ready in_ready=%b expected 11", in_ready);
      end
   endtask

   // Early-exit instance across MSB-differ, LSB-differ, equal and mid-bit cases
   task automatic test_early_exit();
      logic [3:0] va[4] = '{4'b1010, 4'b1010, 4'b0101, 4'b1100};
      logic [3:0] vb[4] = '{4'b0110, 4'b1011, 4'b0101, 4'b1110};
      exp_t e;
      int lat;
      for (int i = 0; i < 4; i++) begin
         start_cmp(0, va[i], vb[i]);
         wait_result(0, 1'b0, lat);
         e = sb.pop_front();
         checks++;
         if (lat != e.lat) begin
            errors++;
            $display("FAIL ee_latency vec=%0d got %0d edges expected %0d", i, lat, e.lat);
         end
         checks++;
         if (get_res(e.sel) !== e.res) begin
            errors++;
            $display("FAIL ee_result vec=%0d got %b expected %b", i, get_res(e.sel), e.res);
         end
         drain(0);
         checks++;
         if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL ee_drain vec=%0d out_valid=%b in_ready=%b expected 0/1", i, out_valid[0], in_ready[0]);
         end
      end
   endtask

   // Full-scan instance: constant latency, first mismatch sticky against later bits
   task automatic test_full_scan();
      logic [3:0] va[4] = '{4'b1000, 4'b0001, 4'b0110, 4'b0000};
      logic [3:0] vb[4] = '{4'b0111, 4'b0000, 4'b0110, 4'b1111};
      exp_t e;
      int lat;
      for (int i = 0; i < 4; i++) begin
         start_cmp(1, va[i], vb[i]);
         wait_result(1, 1'b0, lat);
         e = sb.pop_front();
         checks++;
         if (lat != e.lat) begin
            errors++;
            $display("FAIL fs_latency vec=%0d got %0d edges expected %0d", i, lat, e.lat);
         end
         checks++;
         if (get_res(e.sel) !== e.res) begin
            errors++;
            $display("FAIL fs_result vec=%0d got %b expected %b", i, get_res(e.sel), e.res);
         end
         drain(1);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int lat;
      start_cmp(0, 4'b1001, 4'b0010);
      wait_result(0, 1'b0, lat);
      e = sb.pop_front();
      checks++;
      if (get_res(0) !== e.res) begin
         errors++;
         $display("FAIL bp_result got %b expected %b", get_res(0), e.res);
      end
      a = 4'h0;
      b = 4'hF;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid[0] !== 1'b1 || get_res(0) !== e.res || in_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d out_valid=%b res=%b in_ready=%b busy=%b expected 1/%b/0/0",
                     i, out_valid[0], get_res(0), in_ready[0], busy[0], e.res);
         end
      end
      in_valid[0] = 1'b0;
      drain(0);
      checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid[0], in_ready[0], busy[0]);
      end
   endtask

   // in_valid held through the drain edge must only be taken on the following edge
   task automatic test_back_to_back();
      exp_t e;
      int lat;
      start_cmp(0, 4'b0011, 4'b0010);
      wait_result(0, 1'b0, lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || get_res(0) !== e.res) begin
         errors++;
         $display("FAIL b2b_first lat=%0d res=%b expected %0d/%b", lat, get_res(0), e.lat, e.res);
      end
      a = 4'b0100;
      b = 4'b1000;
      in_valid[0] = 1'b1;
      drain(0);
      checks++;
      if (busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_no_same_cycle busy=%b in_ready=%b expected 0/1", busy[0], in_ready[0]);
      end
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      sb.push_back('{0, exp_res(4'b0100, 4'b1000), exp_lat(0, 4'b0100, 4'b1000)});
      checks++;
      if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept busy=%b in_ready=%b expected 1/0", busy[0], in_ready[0]);
      end
      wait_result(0, 1'b0, lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || get_res(0) !== e.res) begin
         errors++;
         $display("FAIL b2b_second lat=%0d res=%b expected %0d/%b", lat, get_res(0), e.lat, e.res);
      end
      drain(0);
   endtask

   task automatic test_reset_mid_run();
      exp_t e;
      int lat;
      bit stale;
      a = 4'h5;
      b = 4'h5;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      checks++;
      if (busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_run_entry busy=%b expected 1", busy[0]);
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0 || res0 !== 3'b000) begin
         errors++;
         $display("FAIL rst_async out_valid=%b busy=%b in_ready=%b res=%b expected 0/0/0/000",
                  out_valid[0], busy[0], in_ready[0], res0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_ready in_ready=%b expected 1", in_ready[0]);
      end
      stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid[0] !== 1'b0) stale = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (stale) begin
         errors++;
         $display("FAIL rst_stale out_valid seen=1 expected 0");
      end
      start_cmp(0, 4'hF, 4'hF);
      wait_result(0, 1'b0, lat);
      e = sb.pop_front();
      checks++;
      if (lat != e.lat || get_res(0) !== e.res) begin
         errors++;
         $display("FAIL rst_fresh lat=%0d res=%b expected %0d/%b", lat, get_res(0), e.lat, e.res);
      end
      drain(0);
   endtask

   // Operand inputs wander every RUN cycle; only the latched pair may matter
   task automatic test_input_stability();
      exp_t e;
      int lat;
      for (int s = 0; s < 2; s++) begin
         start_cmp(s, 4'h3, 4'h5);
         wait_result(s, 1'b1, lat);
         e = sb.pop_front();
         checks++;
         if (lat != e.lat || get_res(s) !== e.res) begin
            errors++;
            $display("FAIL stab sel=%0d lat=%0d res=%b expected %0d/%b", s, lat, get_res(s), e.lat, e.res);
         end
         drain(s);
      end
   endtask

   initial begin
      test_reset();
      test_early_exit();
      test_full_scan();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      test_input_stability();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty left=%0d expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout time=%0t limit=200000", $time);
      $fatal(1, "timeout");
   end

endmodule
